// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, hold/bubble control, load-use detect and perf counters.
// Latency: one cycle decode->execute; load_use_hazard is combinational from registered state.
// Backpressure: stall holds all contents; flush overrides stall and inserts a NOP bubble.
module id_ex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 14,
  parameter int REG_W       = 5,
  parameter     CTRL_NOP    = 14'd1,
  parameter int MEMREAD_BIT = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] pc_4_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [DATA_W-1:0] offset_in,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic [REG_W-1:0]  if_id_rd,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] pc_4_out,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  output logic [DATA_W-1:0] offset_out,
  output logic [REG_W-1:0]  id_ex_rs,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_rd,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CTRL_W-1:0] NOP_V = CTRL_W'(CTRL_NOP);

  // A NOP encoding that does not fit the control bundle would be silently truncated.
  if ((CTRL_NOP >> CTRL_W) != 0) begin : g_ctrl_nop_too_wide
    $error("id_ex_pipe_reg: CTRL_NOP does not fit in CTRL_W bits");
  end
  if (MEMREAD_BIT >= CTRL_W) begin : g_memread_out_of_range
    $error("id_ex_pipe_reg: MEMREAD_BIT outside control bundle");
  end

  logic hold_edge;
  logic bubble_edge;

  // Classify this edge: a held cycle, or a cycle where a bubble enters EX.
  always_comb begin
    hold_edge   = stall & ~flush;
    bubble_edge = flush | (~stall & ~in_valid);
  end

  // Stage contents: flush beats stall beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out   <= 1'b0;
      control_out <= NOP_V;
      pc_4_out    <= '0;
      rs_out      <= '0;
      rt_out      <= '0;
      offset_out  <= '0;
      id_ex_rs    <= '0;
      id_ex_rt    <= '0;
      id_ex_rd    <= '0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      control_out <= NOP_V;
      pc_4_out    <= '0;
      rs_out      <= '0;
      rt_out      <= '0;
      offset_out  <= '0;
      id_ex_rs    <= '0;
      id_ex_rt    <= '0;
      id_ex_rd    <= '0;
    end else if (!stall) begin
      valid_out   <= in_valid;
      // An empty decode slot must not carry live write/memory enables into EX.
      control_out <= in_valid ? control_in : NOP_V;
      pc_4_out    <= pc_4_in;
      rs_out      <= rs_in;
      rt_out      <= rt_in;
      offset_out  <= offset_in;
      id_ex_rs    <= if_id_rs;
      id_ex_rt    <= if_id_rt;
      id_ex_rd    <= if_id_rd;
    end
  end

  // Load in EX whose destination is a source of the decode instruction; r0 is hardwired zero.
  always_comb begin
    load_use_hazard = valid_out & control_out[MEMREAD_BIT] & (id_ex_rt != '0) &
                      ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
  end

  // Saturating performance counters; clear wins over increment and leaves the stage alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (hold_edge && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bubble_edge && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: scoreboarded stage contents and counters, plus hazard spot checks.
// Two instances share stimulus: default CNT_W=16 and CNT_W=4 for saturation.
module tb_id_ex_pipe_reg;

  localparam logic [13:0] NOP = 14'd1;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [13:0] control_in;
  logic [31:0] pc_4_in;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic [31:0] offset_in;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic [4:0]  if_id_rd;
  logic        cnt_clr;

  logic        valid_out;
  logic [13:0] control_out;
  logic [31:0] pc_4_out;
  logic [31:0] rs_out;
  logic [31:0] rt_out;
  logic [31:0] offset_out;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic        load_use_hazard;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  logic        s_valid_out;
  logic [13:0] s_control_out;
  logic [31:0] s_pc_4_out;
  logic [31:0] s_rs_out;
  logic [31:0] s_rt_out;
  logic [31:0] s_offset_out;
  logic [4:0]  s_id_ex_rs;
  logic [4:0]  s_id_ex_rt;
  logic [4:0]  s_id_ex_rd;
  logic        s_load_use_hazard;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_bubble_cnt;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .control_in(control_in), .pc_4_in(pc_4_in), .rs_in(rs_in), .rt_in(rt_in),
    .offset_in(offset_in), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
    .cnt_clr(cnt_clr), .valid_out(valid_out), .control_out(control_out),
    .pc_4_out(pc_4_out), .rs_out(rs_out), .rt_out(rt_out), .offset_out(offset_out),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .load_use_hazard(load_use_hazard), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .control_in(control_in), .pc_4_in(pc_4_in), .rs_in(rs_in), .rt_in(rt_in),
    .offset_in(offset_in), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
    .cnt_clr(cnt_clr), .valid_out(s_valid_out), .control_out(s_control_out),
    .pc_4_out(s_pc_4_out), .rs_out(s_rs_out), .rt_out(s_rt_out), .offset_out(s_offset_out),
    .id_ex_rs(s_id_ex_rs), .id_ex_rt(s_id_ex_rt), .id_ex_rd(s_id_ex_rd),
    .load_use_hazard(s_load_use_hazard), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct packed {
    logic [157:0] pipe;
    logic [15:0]  sc;
    logic [15:0]  bc;
    logic [3:0]   sc4;
    logic [3:0]   bc4;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [157:0] obs_pipe;
  assign obs_pipe = {valid_out, control_out, pc_4_out, rs_out, rt_out, offset_out,
                     id_ex_rs, id_ex_rt, id_ex_rd};

  // Reference model state
  logic        m_valid;
  logic [13:0] m_ctrl;
  logic [31:0] m_pc, m_rs, m_rt, m_off;
  logic [4:0]  m_ers, m_ert, m_erd;
  logic [15:0] m_sc, m_bc;
  logic [3:0]  m_sc4, m_bc4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = NOP;
    m_pc = '0; m_rs = '0; m_rt = '0; m_off = '0;
    m_ers = '0; m_ert = '0; m_erd = '0;
    m_sc = '0; m_bc = '0; m_sc4 = '0; m_bc4 = '0;
  endtask

  // Advance the model with the inputs currently driven, queue the expectation, then clock.
  task automatic step();
    exp_t e;
    if (flush) begin
      m_valid = 1'b0; m_ctrl = NOP;
      m_pc = '0; m_rs = '0; m_rt = '0; m_off = '0;
      m_ers = '0; m_ert = '0; m_erd = '0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_ctrl  = in_valid ? control_in : NOP;
      m_pc = pc_4_in; m_rs = rs_in; m_rt = rt_in; m_off = offset_in;
      m_ers = if_id_rs; m_ert = if_id_rt; m_erd = if_id_rd;
    end
    if (cnt_clr) begin
      m_sc = '0; m_bc = '0; m_sc4 = '0; m_bc4 = '0;
    end else begin
      if (stall && !flush) begin
        if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (m_sc4 != 4'hF) m_sc4 = m_sc4 + 4'd1;
      end
      if (flush || (!stall && !in_valid)) begin
        if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        if (m_bc4 != 4'hF) m_bc4 = m_bc4 + 4'd1;
      end
    end
    e.pipe = {m_valid, m_ctrl, m_pc, m_rs, m_rt, m_off, m_ers, m_ert, m_erd};
    e.sc = m_sc; e.bc = m_bc; e.sc4 = m_sc4; e.bc4 = m_bc4;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [13:0] c, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] off,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    in_valid = v; control_in = c; pc_4_in = pc; rs_in = rs; rt_in = rt; offset_in = off;
    if_id_rs = a; if_id_rt = b; if_id_rd = d;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; stall = 0; flush = 0; cnt_clr = 0;
    drive(0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_pipe !== {1'b0, NOP, 143'd0}) begin
      errors++; $display("FAIL reset_state: got %h required %h", obs_pipe, {1'b0, NOP, 143'd0});
    end
    reset = 1'b0;
    model_reset();
    drive(1, 14'h0123, 32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3);
    step();
    e = q.pop_front();
    checks++;
    if (obs_pipe !== e.pipe) begin
      errors++; $display("FAIL reset_preload: got %h required %h", obs_pipe, e.pipe);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_pipe !== {1'b0, NOP, 143'd0}) begin
      errors++; $display("FAIL reset_async_pipe: got %h required %h", obs_pipe, {1'b0, NOP, 143'd0});
    end
    checks++;
    if ({stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt} !== 40'd0) begin
      errors++; $display("FAIL reset_async_cnt: got %h %h %h %h required 0",
                         stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load();
    exp_t e;
    drive(1, 14'h2A5, 32'h0000_0044, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010, 5'd4, 5'd6, 5'd8);
    step();
    e = q.pop_front();
    checks++;
    if (obs_pipe !== e.pipe) begin
      errors++; $display("FAIL load_single: got %h required %h", obs_pipe, e.pipe);
    end
    checks++;
    if ({valid_out, control_out, pc_4_out, rt_out} !== {1'b1, 14'h2A5, 32'h44, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL load_fields: got v=%b c=%h pc=%h rt=%h required v=1 c=2a5 pc=44 rt=deadbeef",
                         valid_out, control_out, pc_4_out, rt_out);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 14'h100 + 14'(i), 32'h1000 + 32'(4 * i), $urandom, $urandom, $urandom,
            5'(i + 1), 5'(i + 9), 5'(i + 17));
      step();
      e = q.pop_front();
      checks++;
      if (obs_pipe !== e.pipe) begin
        errors++; $display("FAIL load_b2b[%0d]: got %h required %h", i, obs_pipe, e.pipe);
      end
    end
    checks++;
    if ({stall_cnt, bubble_cnt} !== {e.sc, e.bc}) begin
      errors++; $display("FAIL load_cnt: got %h %h required %h %h", stall_cnt, bubble_cnt, e.sc, e.bc);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    drive(1, 14'h0042, 32'h20, 32'hA, 32'hB, 32'hC, 5'd7, 5'd8, 5'd9);
    step();
    void'(q.pop_front());
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 14'h3C0, 32'h900 + 32'(i), 32'h5, 32'h6, 32'h7, 5'd30, 5'd29, 5'd28);
      step();
      e = q.pop_front();
      checks++;
      if (obs_pipe !== e.pipe || pc_4_out !== 32'h20) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h required %h", i, obs_pipe, e.pipe);
      end
    end
    checks++;
    if (stall_cnt !== 16'd3 || stall_cnt !== e.sc) begin
      errors++; $display("FAIL stall_cnt: got %0d required 3", stall_cnt);
    end
    stall = 1'b0;
    step();
    e = q.pop_front();
    checks++;
    if (obs_pipe !== e.pipe) begin
      errors++; $display("FAIL stall_release: got %h required %h", obs_pipe, e.pipe);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    logic [15:0] sc0, bc0;
    sc0 = stall_cnt; bc0 = bubble_cnt;
    flush = 1'b1; stall = 1'b1;
    step();
    e = q.pop_front();
    flush = 1'b0; stall = 1'b0;
    checks++;
    if (obs_pipe !== {1'b0, NOP, 143'd0} || obs_pipe !== e.pipe) begin
      errors++; $display("FAIL flush_pipe: got %h required %h", obs_pipe, e.pipe);
    end
    checks++;
    if (stall_cnt !== sc0 || bubble_cnt !== bc0 + 16'd1) begin
      errors++; $display("FAIL flush_cnt: got %0d %0d required %0d %0d", stall_cnt, bubble_cnt, sc0, bc0 + 16'd1);
    end
    // Bubble held by stall must not be recounted
    stall = 1'b1;
    step();
    e = q.pop_front();
    stall = 1'b0;
    checks++;
    if (bubble_cnt !== e.bc || obs_pipe !== e.pipe) begin
      errors++; $display("FAIL flush_held: got bc=%0d required %0d", bubble_cnt, e.bc);
    end
    drive(0, 14'h3FFF, 32'h55, 32'h66, 32'h77, 32'h88, 5'd1, 5'd2, 5'd3);
    step();
    e = q.pop_front();
    checks++;
    if (control_out !== NOP || obs_pipe !== e.pipe) begin
      errors++; $display("FAIL invalid_load: got %h required %h", obs_pipe, e.pipe);
    end
    checks++;
    if (bubble_cnt !== bc0 + 16'd2 || s_bubble_cnt !== e.bc4) begin
      errors++; $display("FAIL invalid_cnt: got %0d/%0d required %0d/%0d",
                         bubble_cnt, s_bubble_cnt, bc0 + 16'd2, e.bc4);
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    drive(1, 14'h0008, 32'h4, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd9);
    step();
    e = q.pop_front();
    checks++;
    if (obs_pipe !== e.pipe) begin
      errors++; $display("FAIL hz_load: got %h required %h", obs_pipe, e.pipe);
    end
    if_id_rs = 5'd5; if_id_rt = 5'd7; #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL hz_rs_match: got %b required 1", load_use_hazard);
    end
    if_id_rs = 5'd3; if_id_rt = 5'd5; #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++; $display("FAIL hz_rt_match: got %b required 1", load_use_hazard);
    end
    if_id_rs = 5'd3; if_id_rt = 5'd7; #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hz_no_match: got %b required 0", load_use_hazard);
    end
    drive(1, 14'h0008, 32'h8, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9);
    step();
    void'(q.pop_front());
    if_id_rs = 5'd0; if_id_rt = 5'd0; #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hz_r0: got %b required 0", load_use_hazard);
    end
    drive(1, 14'h0000, 32'hC, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd9);
    step();
    void'(q.pop_front());
    if_id_rs = 5'd5; #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hz_not_load: got %b required 0", load_use_hazard);
    end
    drive(0, 14'h0008, 32'h10, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd9);
    step();
    void'(q.pop_front());
    if_id_rs = 5'd5; #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL hz_invalid: got %b required 0", load_use_hazard);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [157:0] held;
    drive(1, 14'h0155, 32'hABC0, 32'h1, 32'h2, 32'h3, 5'd11, 5'd12, 5'd13);
    step();
    void'(q.pop_front());
    held = obs_pipe;
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      e = q.pop_front();
      if (i % 5 == 4) begin
        checks++;
        if (s_stall_cnt !== e.sc4 || stall_cnt !== e.sc) begin
          errors++; $display("FAIL sat_track[%0d]: got %h/%h required %h/%h",
                             i, s_stall_cnt, stall_cnt, e.sc4, e.sc);
        end
      end
    end
    checks++;
    if (s_stall_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_value: got %h required f", s_stall_cnt);
    end
    cnt_clr = 1'b1;
    step();
    e = q.pop_front();
    cnt_clr = 1'b0;
    checks++;
    if ({stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt} !== 40'd0) begin
      errors++; $display("FAIL clr_cnt: got %h %h %h %h required 0",
                         stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt);
    end
    checks++;
    if (obs_pipe !== held || obs_pipe !== e.pipe) begin
      errors++; $display("FAIL clr_pipe: got %h required %h", obs_pipe, held);
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_hazard();
    test_saturation();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register, the successor to the fixed 32-bit decode/execute latch. It adds:
- a valid bit;
- a stall (hold) input and a flush input that inserts a NOP bubble;
- load-use hazard detection against the instruction currently in decode;
- saturating stall and bubble performance counters.

It sits between the decode stage and the ALU/forwarding logic of the 5-stage pipeline.

Parameters:
DATA_W, 32, width of pc_4, rs, rt and offset data fields
CTRL_W, 14, width of the control bundle
REG_W, 5, register specifier width
CTRL_NOP, 14'd1, control value driven for reset/bubble (all writes and memory ops disabled)
MEMREAD_BIT, 3, index of the mem-read bit within the control bundle
CNT_W, 16, performance counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all stage contents this cycle
flush  in  1  replace stage contents with a bubble
in_valid  in  1  decode stage holds a real instruction
control_in  in  CTRL_W  decoded control bundle
pc_4_in, rs_in, rt_in, offset_in  in  DATA_W each  decode data fields
if_id_rs, if_id_rt, if_id_rd  in  REG_W each  register specifiers from IF/ID
cnt_clr  in  1  synchronous clear of both counters
valid_out  out  1  EX stage holds a real instruction
control_out  out  CTRL_W  registered control
pc_4_out, rs_out, rt_out, offset_out  out  DATA_W each  registered data
id_ex_rs, id_ex_rt, id_ex_rd  out  REG_W each  registered specifiers
load_use_hazard  out  1  combinational load-use stall request to the hazard unit
stall_cnt  out  CNT_W  saturating count of stalled cycles
bubble_cnt  out  CNT_W  saturating count of bubbles entered

Behaviour:
- Reset is asynchronous and active-high. While reset=1:
  - valid_out=0 and control_out=CTRL_NOP.
  - All data and specifier outputs are 0.
  - stall_cnt=0 and bubble_cnt=0.
  - Reset asserted mid-operation discards the stage contents immediately, without waiting for a clock edge.
- Per rising edge, priority is flush > stall > load:
  - flush=1 (regardless of stall): valid_out<=0, control_out<=CTRL_NOP, and all data/specifier outputs <=0.
  - stall=1, flush=0: every register holds its value, including valid_out.
  - Otherwise (load): all fields capture their inputs and valid_out<=in_valid. If in_valid=0, control_out<=CTRL_NOP instead of control_in; data fields are still captured.
- Latency: exactly one cycle from input to output for a load; no combinational path from data inputs to data outputs.
- load_use_hazard = valid_out & control_out[MEMREAD_BIT] & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt)).
  - Purely combinational, evaluated from the registered state and the current IF/ID specifiers.
  - Register 0 never raises a hazard.
  - The block does not act on this signal itself. The hazard unit turns it into stall/flush requests.
- stall_cnt:
  - Increments on each edge where stall=1 and flush=0.
  - Saturates at all-ones, with no wrap-around.
- bubble_cnt:
  - Increments on each edge where a bubble enters: flush=1, or a load with in_valid=0.
  - Saturates at all-ones.
  - A held bubble during stall does not count again.
- cnt_clr:
  - Clears both counters at the next edge.
  - Has priority over increment in the same cycle.
  - Does not affect pipeline contents.
- Simultaneous flush and stall: flush wins; stall_cnt does not increment, bubble_cnt does.
- Width rules: all comparisons are REG_W wide, and counters are unsigned CNT_W. Any CTRL_NOP value wider than CTRL_W is a configuration error, checked at elaboration.

Test Plan:
1. Reset: assert reset=1 asynchronously mid-cycle with the stage loaded (pc_4_out=32'h100) -> immediately valid_out=0, control_out=14'd1, all data 0, counters 0.
2. Normal load: in_valid=1, control_in=14'h2A5, pc_4_in=32'h0000_0044, rt_in=32'hDEAD_BEEF -> one edge later outputs match and valid_out=1. Back-to-back loads over 4 cycles track inputs with 1-cycle latency.
3. Stall hold: load pc_4_in=32'h20, then stall=1 for 3 cycles while inputs change -> outputs stay at 32'h20 and stall_cnt=3. Releasing stall loads the current inputs on the next edge.
4. Flush priority: flush=1 and stall=1 in the same cycle with a valid stage -> valid_out=0, control_out=14'd1, data 0, bubble_cnt+1, stall_cnt unchanged. in_valid=0 load -> control_out=14'd1 and bubble_cnt+1.
5. Load-use hazard: stage holds mem-read with id_ex_rt=5, if_id_rs=5 -> load_use_hazard=1. Same setup with if_id_rt=5 -> 1; with id_ex_rt=0 and if_id_rs=0 -> 0; with valid_out=0 -> 0.
6. Counter saturation/clear: CNT_W=4, stall held for 20 cycles -> stall_cnt=4'hF and holds. Assert cnt_clr together with stall -> next edge stall_cnt=0, pipeline contents unchanged.
